// File: rtl/bullet_slot_arbiter_if.sv
// Handshake bundle between the game logic and bullet_slot_arbiter.
// The per-slot free request is called slot_release because "release" is a reserved word.
interface bullet_slot_arbiter_if #(
    parameter int SLOTS = 4,
    parameter int IDW   = 2
);
    logic             enable;
    logic             p1_fire;
    logic             p2_fire;
    logic [SLOTS-1:0] slot_release;
    logic             grant_valid;
    logic             grant_player;
    logic [IDW-1:0]   grant_slot;
    logic [SLOTS-1:0] slot_busy;
    logic [SLOTS-1:0] slot_owner;
    logic             p1_ready;
    logic             p2_ready;
    logic [7:0]       drop_count;

    modport slave (
        input  enable, p1_fire, p2_fire, slot_release,
        output grant_valid, grant_player, grant_slot,
               slot_busy, slot_owner, p1_ready, p2_ready, drop_count
    );

    modport master (
        output enable, p1_fire, p2_fire, slot_release,
        input  grant_valid, grant_player, grant_slot,
               slot_busy, slot_owner, p1_ready, p2_ready, drop_count
    );
endinterface

// File: rtl/bullet_slot_arbiter.sv
// Shares SLOTS bullet slots between two players: fire edge detect, refire cooldown,
// round-robin tie break, lowest-free-slot grant. Define BULLET_DROP_CNT_EN for drop_count.
module bullet_slot_arbiter #(
    parameter int SLOTS    = 4,
    parameter int IDW      = 2,
    parameter int COOLDOWN = 8
) (
    input  logic                  game_clk,
    input  logic                  reset,
    bullet_slot_arbiter_if.slave  bus
);
    // Player vectors: bit 0 = P1, bit 1 = P2.
    logic [1:0]       fire;
    logic [1:0]       press;
    logic [1:0]       ready;
    logic [1:0]       won;
    logic [1:0]       fire_d_q, fire_d_d;
    logic [1:0]       pending_q, pending_d;
    logic [1:0][7:0]  cd_q, cd_d;
    logic             rr_q, rr_d;
    logic [SLOTS-1:0] slot_busy_q, slot_busy_d;
    logic [SLOTS-1:0] slot_owner_q, slot_owner_d;
    logic             grant_valid_q, grant_valid_d;
    logic             grant_player_q, grant_player_d;
    logic [IDW-1:0]   grant_slot_q, grant_slot_d;

    logic [SLOTS-1:0] free;
    logic             any_free;
    logic [IDW-1:0]   free_idx;
    logic             grant_en;
    logic             winner;

    assign fire     = {bus.p2_fire, bus.p1_fire};
    assign free     = ~slot_busy_q;
    assign any_free = |free;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_player
            assign ready[gi] = (cd_q[gi] == 8'd0);
            assign press[gi] = fire[gi] & ~fire_d_q[gi];
        end
    endgenerate

    // Lowest-index free slot; releases this tick are deliberately not considered.
    always_comb begin
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (free[i]) begin
                free_idx = IDW'(i);
            end
        end
    end

    always_comb begin
        grant_en = bus.enable & any_free & (|pending_q);
        winner   = (pending_q == 2'b11) ? rr_q : pending_q[1];
        won      = {grant_en & winner, grant_en & ~winner};
    end

    always_comb begin
        fire_d_d       = fire;
        pending_d      = pending_q;
        rr_d           = rr_q;
        slot_busy_d    = slot_busy_q & ~bus.slot_release;
        slot_owner_d   = slot_owner_q;
        grant_valid_d  = 1'b0;
        grant_player_d = grant_player_q;
        grant_slot_d   = grant_slot_q;

        for (int p = 0; p < 2; p++) begin
            cd_d[p] = (cd_q[p] == 8'd0) ? 8'd0 : cd_q[p] - 8'd1;
            if (!bus.enable) begin
                pending_d[p] = 1'b0;
            end else if (pending_q[p]) begin
                pending_d[p] = any_free & ~won[p];
            end else begin
                pending_d[p] = press[p] & ready[p];
            end
            if (won[p]) begin
                cd_d[p] = 8'(COOLDOWN);
            end
        end

        if (grant_en) begin
            slot_busy_d[free_idx]  = 1'b1;
            slot_owner_d[free_idx] = winner;
            rr_d                   = ~winner;
            grant_valid_d          = 1'b1;
            grant_player_d         = winner;
            grant_slot_d           = free_idx;
        end
    end

    // fire_d resets high so a button held through reset is not seen as a press.
    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            fire_d_q       <= 2'b11;
            pending_q      <= 2'b00;
            cd_q           <= '0;
            rr_q           <= 1'b0;
            slot_busy_q    <= '0;
            slot_owner_q   <= '0;
            grant_valid_q  <= 1'b0;
            grant_player_q <= 1'b0;
            grant_slot_q   <= '0;
        end else begin
            fire_d_q       <= fire_d_d;
            pending_q      <= pending_d;
            cd_q           <= cd_d;
            rr_q           <= rr_d;
            slot_busy_q    <= slot_busy_d;
            slot_owner_q   <= slot_owner_d;
            grant_valid_q  <= grant_valid_d;
            grant_player_q <= grant_player_d;
            grant_slot_q   <= grant_slot_d;
        end
    end

`ifdef BULLET_DROP_CNT_EN
    logic [7:0] drop_count_q, drop_count_d;
    logic [8:0] drop_sum;

    // Every request still pending when the pool is full is dropped this tick.
    always_comb begin
        drop_sum = {1'b0, drop_count_q};
        if (bus.enable && !any_free) begin
            drop_sum = drop_sum + 9'(pending_q[0]) + 9'(pending_q[1]);
        end
        drop_count_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    end

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            drop_count_q <= 8'd0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign bus.drop_count = drop_count_q;
`else
    assign bus.drop_count = 8'd0;
`endif

    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_player = grant_player_q;
    assign bus.grant_slot   = grant_slot_q;
    assign bus.slot_busy    = slot_busy_q;
    assign bus.slot_owner   = slot_owner_q;
    assign bus.p1_ready     = ready[0];
    assign bus.p2_ready     = ready[1];
endmodule
